mp_add_sequencer: RTL and testbench

Sequencing controller that performs WORDS×32-bit two's-complement addition or subtraction using a single 32-bit adder slice (a + b + carry-in), one limb per cycle, least-significant limb first.
- Accepts a full-width operand pair over a valid/ready handshake.
- Chains the carry between limbs through a register.
- Presents the full-width result with carry, signed overflow and zero flags over a second valid/ready handshake.
- Sits between a wide-arithmetic requester and the shared 32-bit adder datapath, so the design does not need a WORDS×32-bit combinational adder.

---
 rtl/mp_add_sequencer.sv | 133 +++++++++++++
 tb/tb_mp_add_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer
// Multi-precision add/subtract controller. A WORDS x 32-bit operand pair is
// latched, then summed one 32-bit limb per cycle (least-significant first)
// with the carry chained through a register. The result is presented with
// carry-out, signed-overflow and zero flags.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (a, b, cin, sub)
//   abort               synchronous cancel while RUN or DONE
//   out_valid/out_ready result handshake (s, cout, pos/neg_overflow, zero)
//   busy                operation in flight (RUN or DONE)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding limb idx_q each cycle, carry held in carry_q
// DONE  | result valid, held until out_ready or abort

module mp_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORDS*32-1:0]   a,
    input  logic [WORDS*32-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORDS*32-1:0]   s,
    output logic                  cout,
    output logic                  pos_overflow,
    output logic                  neg_overflow,
    output logic                  zero,
    output logic                  busy
);

    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [WORDS-1:0][31:0]   a_q;
    logic [WORDS-1:0][31:0]   b_q;
    logic [WORDS-1:0][31:0]   s_q;
    logic [WORDS-1:0][31:0]   s_d;
    logic [IW-1:0]            idx_q;
    logic                     carry_q;
    logic                     cout_q;
    logic                     pos_ovf_q;
    logic                     neg_ovf_q;
    logic                     zero_q;
    logic [32:0]              limb_sum;

    // Shared 32-bit adder slice; s_d is the result register with the current
    // limb merged in, so the zero flag sees the completed value on the last limb.
    always_comb begin
        limb_sum = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {32'd0, carry_q};
        s_d = s_q;
        s_d[idx_q] = limb_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            pos_ovf_q <= 1'b0;
            neg_ovf_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        // Subtraction as a + ~b + 1: invert B here, force carry-in to 1.
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | cin;
                        idx_q   <= '0;
                        s_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        s_q     <= s_d;
                        carry_q <= limb_sum[32];
                        if (idx_q == LAST_IDX) begin
                            cout_q    <= limb_sum[32];
                            pos_ovf_q <= ~a_q[WORDS-1][31] & ~b_q[WORDS-1][31] &  limb_sum[31];
                            neg_ovf_q <=  a_q[WORDS-1][31] &  b_q[WORDS-1][31] & ~limb_sum[31];
                            zero_q    <= (s_d == '0);
                            state_q   <= DONE;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q == RUN) || (state_q == DONE);
    assign s            = s_q;
    assign cout         = cout_q;
    assign pos_overflow = pos_ovf_q;
    assign neg_overflow = neg_ovf_q;
    assign zero         = zero_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Bench for mp_add_sequencer: directed cases plus randomized operations,
// each compared against a full-width arithmetic reference model.
module tb_mp_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = WORDS * 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           cin = 1'b0;
    logic           sub = 1'b0;
    logic           abort = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   s;
    logic           cout;
    logic           pos_overflow;
    logic           neg_overflow;
    logic           zero;
    logic           busy;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_s;
    logic         exp_cout, exp_pos, exp_neg, exp_zero;

    mp_add_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .pos_overflow(pos_overflow),
        .neg_overflow(neg_overflow), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-operand arithmetic, signs taken from the effective operands.
    task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                             input logic rcin, input logic rsub);
        logic [W:0]   full;
        logic [W-1:0] eb;
        eb   = rsub ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, eb} + {{W{1'b0}}, (rsub ? 1'b1 : rcin)};
        exp_s    = full[W-1:0];
        exp_cout = full[W];
        exp_pos  = !ra[W-1] && !eb[W-1] &&  full[W-1];
        exp_neg  =  ra[W-1] &&  eb[W-1] && !full[W-1];
        exp_zero = (full[W-1:0] == '0);
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 5))
                0:       v[i*32 +: 32] = 32'hFFFF_FFFF;
                1:       v[i*32 +: 32] = 32'h0;
                2:       v[i*32 +: 32] = 32'h8000_0000;
                default: v[i*32 +: 32] = $urandom;
            endcase
        end
        return v;
    endfunction

    // Accept one operation and wait for out_valid; checks latency.
    task automatic start_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                            input logic ocin, input logic osub);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check_eq({tag, "_ready"}, in_ready, 1'b1);
        ref_model(oa, ob, ocin, osub);
        a = oa; b = ob; cin = ocin; sub = osub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = rand_wide(); b = rand_wide(); cin = $urandom; sub = $urandom;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check_eq({tag, "_latency"}, n, WORDS);
    endtask

    task automatic check_result(input string tag);
        check_eq({tag, "_s"},    s,            exp_s);
        check_eq({tag, "_cout"}, cout,         exp_cout);
        check_eq({tag, "_pos"},  pos_overflow, exp_pos);
        check_eq({tag, "_neg"},  neg_overflow, exp_neg);
        check_eq({tag, "_zero"}, zero,         exp_zero);
        check_eq({tag, "_busy"}, {in_ready, busy}, 2'b01);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_idle"}, {in_ready, out_valid, busy}, 3'b100);
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                           input logic ocin, input logic osub);
        start_op(tag, oa, ob, ocin, osub);
        check_result(tag);
        handshake(tag);
    endtask

    initial begin
        logic [W-1:0] ones, maxpos, minneg;
        ones   = '1;
        maxpos = {1'b0, {(W-1){1'b1}}};
        minneg = {1'b1, {(W-1){1'b0}}};

        #2;
        check_eq("rst_flags", {in_ready, out_valid, cout, pos_overflow, neg_overflow, zero, busy}, 7'b1000000);
        check_eq("rst_s", s, '0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        full_op("ones_plus1", ones, W'(1), 1'b0, 1'b0);
        check_eq("ones_plus1_zero_exp", {exp_zero, exp_cout}, 2'b11);
        full_op("maxpos_plus1", maxpos, W'(1), 1'b0, 1'b0);
        full_op("minneg_x2", minneg, minneg, 1'b0, 1'b0);
        full_op("sub_5_7", W'(5), W'(7), 1'b0, 1'b1);
        full_op("sub_7_5", W'(7), W'(5), 1'b1, 1'b1);
        full_op("carry_chain", {32'h0, {96{1'b1}}}, '0, 1'b1, 1'b0);

        // Backpressure: result held for 5 cycles while new operands are offered.
        start_op("bp", rand_wide(), rand_wide(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = rand_wide(); b = rand_wide();
            @(posedge clk); #1;
            check_eq("bp_hold_valid", {out_valid, in_ready}, 2'b10);
            check_result("bp_hold");
        end
        in_valid = 1'b0;
        handshake("bp");

        // Abort on the 2nd RUN cycle; carry-in 1 must not leak into the next op.
        ref_model('1, '1, 1'b1, 1'b0);
        a = '1; b = '1; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_idle", {in_ready, out_valid, busy}, 3'b100);
        for (int i = 0; i < WORDS + 2; i++) begin
            @(posedge clk); #1;
            check_eq("abort_no_valid", out_valid, 1'b0);
        end
        full_op("after_abort", {W{1'b0}} | W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0);

        // Abort while in DONE
        start_op("abort_done", rand_wide(), rand_wide(), 1'b0, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_done_idle", {in_ready, out_valid, busy}, 3'b100);

        // Random operations with random consumer delay
        for (int k = 0; k < 40; k++) begin
            start_op("rnd", rand_wide(), rand_wide(), 1'($urandom), 1'($urandom));
            for (int d = $urandom_range(0, 3); d > 0; d--) begin
                @(posedge clk); #1;
            end
            check_result("rnd");
            handshake("rnd");
        end

        // Reset mid-RUN, after a result that left flags set.
        full_op("pre_rst", maxpos, maxpos, 1'b0, 1'b0);
        a = rand_wide(); b = rand_wide(); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrun_rst_flags", {in_ready, out_valid, cout, pos_overflow, neg_overflow, zero, busy}, 7'b1000000);
        check_eq("midrun_rst_s", s, '0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        full_op("post_rst", rand_wide(), rand_wide(), 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
